// File: rtl/pwm_if.sv
// Control and gate-drive bundle between the commutation logic and the PWM block.
// The master drives enables, period, duty and load; the slave returns gate drives and status.
interface pwm_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3
);
    logic                 ce;
    logic [WIDTH-1:0]     period;
    logic [NCH*WIDTH-1:0] duty;
    logic                 load;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       hi;
    logic [NCH-1:0]       lo;
    logic                 sync;
    logic                 busy;

    modport master (
        output ce, period, duty, load, en,
        input  hi, lo, sync, busy
    );

    modport slave (
        input  ce, period, duty, load, en,
        output hi, lo, sync, busy
    );
endinterface

// File: rtl/pwm_3ph_deadtime.sv
// Edge-aligned multi-channel PWM with shadow-buffered period/duty and
// complementary gate outputs separated by a per-channel dead-time gap.
module pwm_3ph_deadtime #(
    parameter int WIDTH    = 8,
    parameter int NCH      = 3,
    parameter int DEADTIME = 4
) (
    input logic   clk,
    input logic   rst_n,
    pwm_if.slave  bus
);
    localparam logic [WIDTH-1:0] DT_VAL = WIDTH'(DEADTIME);

    logic [WIDTH-1:0]     cnt;
    logic [WIDTH-1:0]     per_act;
    logic [WIDTH-1:0]     per_sh;
    logic [NCH*WIDTH-1:0] duty_act;
    logic [NCH*WIDTH-1:0] duty_sh;
    logic                 busy_q;
    logic                 sync_q;
    logic                 at_tc;
    logic                 commit;

    logic [NCH-1:0]       raw;
    logic [NCH-1:0]       raw_q;
    logic [NCH-1:0]       raw_nxt;
    logic [NCH-1:0]       hi_q;
    logic [NCH-1:0]       lo_q;
    logic [NCH-1:0]       hi_d;
    logic [NCH-1:0]       lo_d;
    logic [WIDTH-1:0]     dt_cnt [NCH];
    logic [WIDTH-1:0]     dt_nxt [NCH];

    assign at_tc  = (cnt == per_act);
    // A load landing on the commit cycle bypasses the shadow and takes effect directly.
    assign commit = bus.ce && at_tc && (busy_q || bus.load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            per_act  <= '0;
            per_sh   <= '0;
            duty_act <= '0;
            duty_sh  <= '0;
            busy_q   <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            sync_q <= bus.ce && (cnt == '0);
            if (bus.ce) begin
                cnt <= at_tc ? '0 : cnt + 1'b1;
            end
            if (bus.load) begin
                per_sh  <= bus.period;
                duty_sh <= bus.duty;
            end
            if (commit) begin
                per_act  <= bus.load ? bus.period : per_sh;
                duty_act <= bus.load ? bus.duty : duty_sh;
                busy_q   <= 1'b0;
            end else if (bus.load) begin
                busy_q <= 1'b1;
            end
        end
    end

    // Gate outputs are derived from the next dead-time state so that EN acts on the
    // very next edge even while CE is low.
    always_comb begin
        raw     = '0;
        raw_nxt = '0;
        hi_d    = '0;
        lo_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            dt_nxt[i]  = dt_cnt[i];
            raw[i]     = (cnt < duty_act[i*WIDTH +: WIDTH]);
            raw_nxt[i] = bus.ce ? raw[i] : raw_q[i];
            if (bus.ce) begin
                if (raw[i] != raw_q[i]) begin
                    dt_nxt[i] = DT_VAL;
                end else if (dt_cnt[i] != '0) begin
                    dt_nxt[i] = dt_cnt[i] - 1'b1;
                end
            end
            hi_d[i] = bus.en[i] && (dt_nxt[i] == '0) && raw_nxt[i];
            lo_d[i] = bus.en[i] && (dt_nxt[i] == '0) && !raw_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                dt_cnt[i] <= '0;
            end
        end else begin
            raw_q <= raw_nxt;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            for (int i = 0; i < NCH; i++) begin
                dt_cnt[i] <= dt_nxt[i];
            end
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.sync = sync_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_pwm_3ph_deadtime.sv
// Randomised and scenario bench for pwm_3ph_deadtime against a cycle-level behavioural model
// that tracks raw-compare history rather than dead-time counters.
module tb_pwm_3ph_deadtime;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int DT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    pwm_if #(.WIDTH(W), .NCH(N)) bus ();

    pwm_3ph_deadtime #(.WIDTH(W), .NCH(N), .DEADTIME(DT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int       m_cnt, m_per, s_per;
    int       m_duty [N];
    int       s_duty [N];
    bit       m_busy, m_sync;
    bit       hist [N][DT+1];   // hist[i][0] is the newest raw-compare value
    bit [N-1:0] exp_hi, exp_lo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task model_reset();
        m_cnt = 0; m_per = 0; s_per = 0; m_busy = 0; m_sync = 0;
        exp_hi = '0; exp_lo = '0;
        for (int i = 0; i < N; i++) begin
            m_duty[i] = 0; s_duty[i] = 0;
            for (int k = 0; k <= DT; k++) hist[i][k] = 1'b0;
        end
    endtask

    task model_step();
        bit raw_new [N];
        bit committed;
        bit stable;
        committed = 1'b0;
        if (bus.ce) begin
            for (int i = 0; i < N; i++) raw_new[i] = (m_cnt < m_duty[i]);
            m_sync = (m_cnt == 0);
            if (m_cnt == m_per) begin
                if (m_busy || bus.load) begin
                    committed = 1'b1;
                    m_per = bus.load ? int'(bus.period) : s_per;
                    for (int i = 0; i < N; i++)
                        m_duty[i] = bus.load ? int'(bus.duty[i*W +: W]) : s_duty[i];
                    m_busy = 1'b0;
                end
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            for (int i = 0; i < N; i++) begin
                for (int k = DT; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = raw_new[i];
            end
        end else begin
            m_sync = 1'b0;
        end
        if (bus.load) begin
            s_per = int'(bus.period);
            for (int i = 0; i < N; i++) s_duty[i] = int'(bus.duty[i*W +: W]);
            if (!committed) m_busy = 1'b1;
        end
        // A gate conducts only once raw has held its level for DT further counted cycles.
        for (int i = 0; i < N; i++) begin
            stable = 1'b1;
            for (int k = 1; k <= DT; k++) if (hist[i][k] != hist[i][0]) stable = 1'b0;
            exp_hi[i] = bus.en[i] && stable && hist[i][0];
            exp_lo[i] = bus.en[i] && stable && !hist[i][0];
        end
    endtask

    task tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("hi", 32'(bus.hi), 32'(exp_hi));
        check("lo", 32'(bus.lo), 32'(exp_lo));
        check("sync", 32'(bus.sync), 32'(m_sync));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("overlap", 32'(bus.hi & bus.lo), 32'd0);
        bus.load = 1'b0;
    endtask

    task set_all(input int per, input int d0, input int d1, input int d2);
        bus.period = W'(per);
        bus.duty   = {W'(d2), W'(d1), W'(d0)};
        bus.load   = 1'b1;
    endtask

    int hi_cnt [N];
    int lo_cnt [N];
    int sync_cnt;

    initial begin
        bus.ce = 1'b1; bus.period = '0; bus.duty = '0; bus.load = 1'b0; bus.en = '1;
        model_reset();
        #12;
        check("rst_hi", 32'(bus.hi), 32'd0);
        check("rst_lo", 32'(bus.lo), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sync", 32'(bus.sync), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 10-cycle period, duty 5, dead-time 2: 3 high, 3 low, two 2-cycle gaps
        set_all(9, 5, 5, 5);
        for (int c = 0; c < 20; c++) tick();
        for (int i = 0; i < N; i++) begin hi_cnt[i] = 0; lo_cnt[i] = 0; end
        sync_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            sync_cnt += int'(bus.sync);
            for (int i = 0; i < N; i++) begin
                hi_cnt[i] += int'(bus.hi[i]);
                lo_cnt[i] += int'(bus.lo[i]);
            end
        end
        for (int i = 0; i < N; i++) begin
            check("hi_count", 32'(hi_cnt[i]), 32'd6);
            check("lo_count", 32'(lo_cnt[i]), 32'd6);
        end
        check("sync_count", 32'(sync_cnt), 32'd2);

        // Mid-period duty update: busy until the wrap, current period keeps old duty
        for (int k = 0; k < 30 && m_cnt != 4; k++) tick();
        check("wait_cnt4", 32'(m_cnt), 32'd4);
        set_all(9, 7, 7, 7);
        tick();
        check("busy_after_load", 32'(bus.busy), 32'd1);
        for (int c = 0; c < 25; c++) tick();

        // Duty extremes: 0% on ch0, 100% on ch1
        set_all(9, 0, 200, 5);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (c > 15) begin
                check("dmin_max_hi", 32'(bus.hi[1:0]), 32'd2);
                check("dmin_max_lo", 32'(bus.lo[1:0]), 32'd1);
            end
        end

        // CE toggling every clock stretches the period to 20 clocks
        set_all(9, 5, 3, 8);
        tick();
        for (int c = 0; c < 40; c++) begin bus.ce = ~bus.ce; tick(); end
        sync_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            bus.ce = ~bus.ce;
            tick();
            sync_cnt += int'(bus.sync);
        end
        check("sync_ce_half", 32'(sync_cnt), 32'd2);
        bus.ce = 1'b1;

        // EN[1] dropped for 7 cycles mid-run
        for (int c = 0; c < 5; c++) tick();
        bus.en = 3'b101;
        for (int c = 0; c < 7; c++) tick();
        check("en1_off_hi", 32'(bus.hi[1]), 32'd0);
        check("en1_off_lo", 32'(bus.lo[1]), 32'd0);
        bus.en = 3'b111;
        for (int c = 0; c < 12; c++) tick();

        // Async reset mid-period
        for (int k = 0; k < 30 && m_cnt != 6; k++) tick();
        check("wait_cnt6", 32'(m_cnt), 32'd6);
        rst_n = 1'b0;
        #1;
        check("arst_hi", 32'(bus.hi), 32'd0);
        check("arst_lo", 32'(bus.lo), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        // Randomised configurations, CE gaps, enable changes and stray loads
        for (int r = 0; r < 25; r++) begin
            int per;
            int d [N];
            per = int'($urandom_range(2, 20));
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 4))
                    0: d[i] = 0;
                    1: d[i] = per + 1 + int'($urandom_range(0, 100));
                    default: d[i] = int'($urandom_range(1, per));
                endcase
            end
            set_all(per, d[0], d[1], d[2]);
            for (int c = 0; c < 60; c++) begin
                bus.ce = ($urandom_range(0, 9) < 8);
                if ($urandom_range(0, 9) == 0) bus.en = N'($urandom_range(0, 7));
                if ($urandom_range(0, 24) == 0)
                    set_all(per, int'($urandom_range(0, per + 2)),
                            int'($urandom_range(0, per + 2)), int'($urandom_range(0, per + 2)));
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
